data_memory_bytelane: RTL

//  Byte-addressed, parametrised data memory for the single-cycle/pipelined core's load/store path.

---
 rtl/data_memory_bytelane.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/data_memory_bytelane.sv
// Byte-addressed RV32 data memory with byte-lane stores, extended loads and a 1-cycle registered response.
// Optional feature macro DMEM_CLEAR_EN: zero the array with a post-reset sweep before accepting requests.
module data_memory_bytelane #(
  parameter int MEMORY_SIZE = 4096,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_address,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_error
);

  localparam int DEPTH = MEMORY_SIZE / 4;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(MEMORY_SIZE);

  logic [31:0] mem_array [DEPTH];

  logic            transfer;
  logic            access_error;
  logic            store_en;
  logic            load_en;
  logic [IDX_W-1:0] word_idx;
  logic [1:0]      lane;
  logic [3:0]      byte_en;
  logic [31:0]     store_lanes;
  logic [31:0]     read_word;
  logic [31:0]     load_data;
  logic [7:0]      sel_byte;
  logic [15:0]     sel_half;

  logic            resp_valid_d, resp_valid_q;
  logic            resp_error_d, resp_error_q;
  logic [31:0]     resp_rdata_d, resp_rdata_q;

`ifdef DMEM_CLEAR_EN
  typedef enum logic {CLEAR, RUN} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] clr_cnt_q, clr_cnt_d;
  logic             clr_en;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Sweep one word per cycle; the last word hands over to RUN on the same edge.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    clr_en    = 1'b0;
    req_ready = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_en    = 1'b1;
        clr_cnt_d = clr_cnt_q + IDX_W'(1);
        if (clr_cnt_q == IDX_W'(DEPTH - 1)) begin
          state_d   = RUN;
          clr_cnt_d = '0;
        end
      end
      RUN: begin
        req_ready = 1'b1;
      end
    endcase
  end
`else
  assign req_ready = 1'b1;
`endif

  always_comb begin
    transfer     = req_valid & req_ready;
    word_idx     = req_address[IDX_W+1:2];
    lane         = req_address[1:0];
    access_error = (req_address >= ADDR_LIMIT);
    byte_en      = 4'b0000;
    store_lanes  = req_wdata;
    case (req_size)
      2'b00: begin
        byte_en     = 4'b0001 << lane;
        store_lanes = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        byte_en     = lane[1] ? 4'b1100 : 4'b0011;
        store_lanes = {2{req_wdata[15:0]}};
        if (lane[0]) access_error = 1'b1;
      end
      2'b10: begin
        byte_en = 4'b1111;
        if (lane != 2'b00) access_error = 1'b1;
      end
      default: begin
        access_error = 1'b1;
      end
    endcase
    store_en = transfer & req_write & ~access_error;
    load_en  = transfer & ~req_write & ~access_error;
  end

  // Stores land at the transfer edge, so a load on the next transfer already sees them.
  always_comb begin
    read_word = mem_array[word_idx];
    sel_byte  = read_word[{lane, 3'b000} +: 8];
    sel_half  = lane[1] ? read_word[31:16] : read_word[15:0];
    load_data = '0;
    case (req_size)
      2'b00:   load_data = {{24{sel_byte[7] & ~req_unsigned}}, sel_byte};
      2'b01:   load_data = {{16{sel_half[15] & ~req_unsigned}}, sel_half};
      2'b10:   load_data = read_word;
      default: load_data = '0;
    endcase
  end

  always_comb begin
    resp_valid_d = transfer;
    resp_rdata_d = resp_rdata_q;
    resp_error_d = resp_error_q;
    if (transfer) begin
      resp_error_d = access_error;
      resp_rdata_d = load_en ? load_data : '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_error_q <= 1'b0;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_error_q <= resp_error_d;
    end
  end

  always_ff @(posedge clk) begin
    if (store_en) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem_array[word_idx][8*b +: 8] <= store_lanes[8*b +: 8];
      end
    end
`ifdef DMEM_CLEAR_EN
    if (clr_en) mem_array[clr_cnt_q] <= '0;
`endif
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_error = resp_error_q;

endmodule
